// File: rtl/reg_write_ctrl.sv
// Write-port controller for the 16x8 register file: round-robin arbitration of
// ALU / load / multiplier writebacks plus the load-pending scoreboard.
module reg_write_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_req,
    input  logic [3:0]  alu_addr,
    input  logic [7:0]  alu_data,
    output logic        alu_gnt,
    input  logic        mem_req,
    input  logic [3:0]  mem_addr,
    input  logic [7:0]  mem_data,
    output logic        mem_gnt,
    input  logic        mul_req,
    input  logic [3:0]  mul_addr,
    input  logic [7:0]  mul_lo,
    input  logic [7:0]  mul_hi,
    output logic        mul_gnt,
    input  logic        mem_issue,
    input  logic [3:0]  mem_issue_addr,
    output logic [15:0] pend,
    output logic [15:0] en_n,
    output logic [7:0]  d,
    output logic [7:0]  mult_high,
    output logic [1:0]  last
);

    localparam logic [3:0] MUL_HI_REG = 4'd11;
    localparam logic [1:0] SEL_ALU    = 2'd0;
    localparam logic [1:0] SEL_MEM    = 2'd1;
    localparam logic [1:0] SEL_MUL    = 2'd2;

    // Handshake: a requester holds req with stable addr/data until it sees its
    // gnt; gnt is combinational and the request is consumed in that same cycle.
    logic [2:0]  req_vec;
    logic [2:0]  gnt_vec;
    logic [15:0] pend_next;

    function automatic logic [15:0] onehot(input logic [3:0] a);
        onehot = 16'h0001 << a;
    endfunction

    assign req_vec = {mul_req, mem_req, alu_req};

    // Priority starts one past the last granted requester and wraps.
    always_comb begin
        gnt_vec = 3'b000;
        if (!reset) begin
            case (last)
                SEL_ALU: begin
                    if (req_vec[1])      gnt_vec = 3'b010;
                    else if (req_vec[2]) gnt_vec = 3'b100;
                    else if (req_vec[0]) gnt_vec = 3'b001;
                end
                SEL_MEM: begin
                    if (req_vec[2])      gnt_vec = 3'b100;
                    else if (req_vec[0]) gnt_vec = 3'b001;
                    else if (req_vec[1]) gnt_vec = 3'b010;
                end
                default: begin
                    if (req_vec[0])      gnt_vec = 3'b001;
                    else if (req_vec[1]) gnt_vec = 3'b010;
                    else if (req_vec[2]) gnt_vec = 3'b100;
                end
            endcase
        end
    end

    assign alu_gnt = gnt_vec[0];
    assign mem_gnt = gnt_vec[1];
    assign mul_gnt = gnt_vec[2];

    // Set is applied after clear so a same-register issue wins.
    always_comb begin
        pend_next = pend;
        if (gnt_vec[1]) pend_next = pend_next & ~onehot(mem_addr);
        if (mem_issue)  pend_next = pend_next | onehot(mem_issue_addr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_n      <= 16'hFFFF;
            d         <= 8'h00;
            mult_high <= 8'h00;
            pend      <= 16'h0000;
            last      <= SEL_MUL;
        end else begin
            en_n <= 16'hFFFF;
            pend <= pend_next;
            if (gnt_vec[0]) begin
                en_n <= ~onehot(alu_addr);
                d    <= alu_data;
                last <= SEL_ALU;
            end else if (gnt_vec[1]) begin
                en_n <= ~onehot(mem_addr);
                d    <= mem_data;
                last <= SEL_MEM;
            end else if (gnt_vec[2]) begin
                // A low byte aimed at the high-byte register is dropped.
                en_n      <= ~(onehot(mul_addr) | onehot(MUL_HI_REG));
                mult_high <= mul_hi;
                if (mul_addr != MUL_HI_REG) d <= mul_lo;
                last      <= SEL_MUL;
            end
        end
    end

endmodule
